// File: rtl/idma_error_policy_unit.sv
// Error policy unit: logs backend error responses and issues CONTINUE/ABORT decisions.
// Latency: decision valid one cycle after the error (auto) or the software decision is accepted.
// Backpressure: error responses stall while a decision is pending; the error log drops entries when full.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   rsp_*                         1D response stream from the backend error handler
//   eh_o / eh_valid_o / eh_ready_i   decision stream back to the error handler (1 = ABORT)
//   auto_i, abort_on_err_i        automatic policy select and its decision value
//   sw_eh_*                       software decision handshake
//   err_*                         error-log FIFO head and pop, sticky overflow flag
//   clear_i                       synchronous clear of counters and overflow flag
//   num_done_o, num_err_o, busy_o status

// Generic registered FIFO: push visible at the head one cycle later.
// Latency: one cycle push-to-head.
// Backpressure: none internally; caller decides what to do when full (push while full is ignored unless popping).
module idma_epu_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_vld,
    input  logic [Width-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [Width-1:0] head_dat,
    output logic             full
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] CntFull = (PtrW+1)'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    cnt_q;
    logic             do_push, do_pop;

    assign full     = (cnt_q == CntFull);
    assign head_vld = (cnt_q != '0);
    // Data is gated so the head reads as zero while empty (including after reset).
    assign head_dat = head_vld ? mem[rd_ptr_q] : '0;

    assign do_pop  = pop_rdy & head_vld;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_vld & (~full | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= push_dat;
    end
endmodule

module idma_error_policy_unit #(
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned CntWidth     = 32,
    parameter int unsigned ErrFifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic                 rsp_error_i,
    input  logic                 rsp_last_i,
    input  logic [1:0]           rsp_cause_i,
    input  logic [1:0]           rsp_err_type_i,
    input  logic [AddrWidth-1:0] rsp_addr_i,
    output logic                 eh_o,
    output logic                 eh_valid_o,
    input  logic                 eh_ready_i,
    input  logic                 auto_i,
    input  logic                 abort_on_err_i,
    input  logic                 sw_eh_i,
    input  logic                 sw_eh_valid_i,
    output logic                 sw_eh_ready_o,
    output logic                 err_valid_o,
    input  logic                 err_ready_i,
    output logic [1:0]           err_cause_o,
    output logic [1:0]           err_type_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic                 err_overflow_o,
    input  logic                 clear_i,
    output logic [CntWidth-1:0]  num_done_o,
    output logic [CntWidth-1:0]  num_err_o,
    output logic                 busy_o
);
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StDecide = 2'd1;
    localparam logic [1:0] StIssue  = 2'd2;

    localparam int unsigned EntryW = 4 + AddrWidth;

    logic [1:0]          state_q, state_d;
    logic                eh_q, eh_d;
    logic [CntWidth-1:0] num_done_q, num_err_q;
    logic                overflow_q;

    logic              rsp_hs, err_acc, done_acc;
    logic              fifo_full, fifo_drop;
    logic [EntryW-1:0] fifo_head;

    // While a decision is outstanding only error responses are held back;
    // clean completions keep flowing so the pipeline behind us does not stall.
    assign rsp_ready_o = (state_q == StIdle) ? 1'b1 : ~rsp_error_i;
    assign rsp_hs      = rsp_valid_i & rsp_ready_o;
    assign err_acc     = rsp_hs & rsp_error_i;
    assign done_acc    = rsp_hs & ~rsp_error_i & rsp_last_i;

    assign sw_eh_ready_o = (state_q == StDecide);
    assign eh_valid_o    = (state_q == StIssue);
    assign eh_o          = (state_q == StIssue) & eh_q;
    assign busy_o        = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        eh_d    = eh_q;
        case (state_q)
            StIdle: begin
                if (err_acc) begin
                    if (auto_i) begin
                        state_d = StIssue;
                        eh_d    = abort_on_err_i;
                    end else begin
                        state_d = StDecide;
                    end
                end
            end
            StDecide: begin
                if (sw_eh_valid_i) begin
                    state_d = StIssue;
                    eh_d    = sw_eh_i;
                end
            end
            StIssue: begin
                if (eh_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            eh_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            eh_q    <= eh_d;
        end
    end

    idma_epu_fifo #(
        .Width (EntryW),
        .Depth (ErrFifoDepth)
    ) i_err_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (err_acc),
        .push_dat ({rsp_cause_i, rsp_err_type_i, rsp_addr_i}),
        .pop_rdy  (err_ready_i),
        .head_vld (err_valid_o),
        .head_dat (fifo_head),
        .full     (fifo_full)
    );

    assign err_cause_o = fifo_head[EntryW-1 -: 2];
    assign err_type_o  = fifo_head[AddrWidth +: 2];
    assign err_addr_o  = fifo_head[AddrWidth-1:0];

    // Dropped only when full and not popping in the same cycle.
    assign fifo_drop = err_acc & fifo_full & ~err_ready_i;

    // clear_i wins over any same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            num_done_q <= '0;
            num_err_q  <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            num_done_q <= '0;
            num_err_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (done_acc) num_done_q <= num_done_q + 1'b1;
            if (err_acc && (num_err_q != '1)) num_err_q <= num_err_q + 1'b1;
            if (fifo_drop) overflow_q <= 1'b1;
        end
    end

    assign num_done_o     = num_done_q;
    assign num_err_o      = num_err_q;
    assign err_overflow_o = overflow_q;
endmodule

// File: tb/tb_idma_error_policy_unit.sv
module tb_idma_error_policy_unit;
    localparam int AW = 64;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          rsp_valid_i = 0, rsp_error_i = 0, rsp_last_i = 0;
    logic [1:0]    rsp_cause_i = 0, rsp_err_type_i = 0;
    logic [AW-1:0] rsp_addr_i = 0;
    logic          rsp_ready_o, eh_o, eh_valid_o;
    logic          eh_ready_i = 0, auto_i = 0, abort_on_err_i = 0;
    logic          sw_eh_i = 0, sw_eh_valid_i = 0, sw_eh_ready_o;
    logic          err_valid_o, err_ready_i = 0;
    logic [1:0]    err_cause_o, err_type_o;
    logic [AW-1:0] err_addr_o;
    logic          err_overflow_o, clear_i = 0, busy_o;
    logic [CW-1:0] num_done_o, num_err_o;

    int errors = 0;
    int checks = 0;

    idma_error_policy_unit #(.AddrWidth(AW), .CntWidth(CW), .ErrFifoDepth(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_error_i(rsp_error_i),
        .rsp_last_i(rsp_last_i), .rsp_cause_i(rsp_cause_i), .rsp_err_type_i(rsp_err_type_i),
        .rsp_addr_i(rsp_addr_i), .eh_o(eh_o), .eh_valid_o(eh_valid_o), .eh_ready_i(eh_ready_i),
        .auto_i(auto_i), .abort_on_err_i(abort_on_err_i), .sw_eh_i(sw_eh_i),
        .sw_eh_valid_i(sw_eh_valid_i), .sw_eh_ready_o(sw_eh_ready_o),
        .err_valid_o(err_valid_o), .err_ready_i(err_ready_i), .err_cause_o(err_cause_o),
        .err_type_o(err_type_o), .err_addr_o(err_addr_o), .err_overflow_o(err_overflow_o),
        .clear_i(clear_i), .num_done_o(num_done_o), .num_err_o(num_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic err_rsp(input logic [1:0] cause, input logic [1:0] typ, input logic [AW-1:0] addr);
        rsp_valid_i = 1; rsp_error_i = 1; rsp_last_i = 0;
        rsp_cause_i = cause; rsp_err_type_i = typ; rsp_addr_i = addr;
    endtask

    task automatic no_rsp();
        rsp_valid_i = 0; rsp_error_i = 0; rsp_last_i = 0;
    endtask

    task automatic test_reset();
        #2 rst_ni = 0;
        #1;
        checks++; if (rsp_ready_o !== 1'b1) begin errors++; $display("FAIL reset_rsp_ready got=%b exp=1", rsp_ready_o); end
        checks++; if (eh_valid_o !== 1'b0 || eh_o !== 1'b0) begin errors++; $display("FAIL reset_eh got=%b%b exp=00", eh_valid_o, eh_o); end
        checks++; if (busy_o !== 1'b0 || sw_eh_ready_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b%b exp=00", busy_o, sw_eh_ready_o); end
        checks++; if (err_valid_o !== 1'b0 || err_overflow_o !== 1'b0 || err_addr_o !== '0) begin errors++; $display("FAIL reset_err got=%b%b %h exp=00 0", err_valid_o, err_overflow_o, err_addr_o); end
        checks++; if (num_done_o !== '0 || num_err_o !== '0) begin errors++; $display("FAIL reset_cnt got=%0d,%0d exp=0,0", num_done_o, num_err_o); end
        @(posedge clk_i); #1 rst_ni = 1;
        tick();
    endtask

    task automatic test_auto_abort();
        auto_i = 1; abort_on_err_i = 1;
        err_rsp(2'd2, 2'd1, 64'h1000);
        #1;
        checks++; if (rsp_ready_o !== 1'b1) begin errors++; $display("FAIL auto_rsp_ready got=%b exp=1", rsp_ready_o); end
        tick(); no_rsp(); #1;
        checks++; if (eh_valid_o !== 1'b1 || eh_o !== 1'b1) begin errors++; $display("FAIL auto_eh got=%b%b exp=11", eh_valid_o, eh_o); end
        checks++; if (err_valid_o !== 1'b1 || err_cause_o !== 2'd2 || err_type_o !== 2'd1 || err_addr_o !== 64'h1000)
            begin errors++; $display("FAIL auto_log got=%b %0d %0d %h exp=1 2 1 1000", err_valid_o, err_cause_o, err_type_o, err_addr_o); end
        checks++; if (num_err_o !== 4'd1) begin errors++; $display("FAIL auto_num_err got=%0d exp=1", num_err_o); end
        eh_ready_i = 1; tick(); eh_ready_i = 0; #1;
        checks++; if (busy_o !== 1'b0 || eh_valid_o !== 1'b0) begin errors++; $display("FAIL auto_return got=%b%b exp=00", busy_o, eh_valid_o); end
        err_ready_i = 1; tick(); err_ready_i = 0; #1;
        checks++; if (err_valid_o !== 1'b0) begin errors++; $display("FAIL auto_pop got=%b exp=0", err_valid_o); end
    endtask

    task automatic test_sw_continue();
        auto_i = 0;
        err_rsp(2'd3, 2'd2, 64'h2000);
        tick(); no_rsp(); #1;
        checks++; if (sw_eh_ready_o !== 1'b1 || eh_valid_o !== 1'b0) begin errors++; $display("FAIL sw_wait got=%b%b exp=10", sw_eh_ready_o, eh_valid_o); end
        tick(); tick();
        checks++; if (sw_eh_ready_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL sw_hold got=%b%b exp=11", sw_eh_ready_o, busy_o); end
        sw_eh_i = 0; sw_eh_valid_i = 1;
        tick(); sw_eh_valid_i = 0; #1;
        checks++; if (eh_valid_o !== 1'b1 || eh_o !== 1'b0 || sw_eh_ready_o !== 1'b0) begin errors++; $display("FAIL sw_issue got=%b%b%b exp=100", eh_valid_o, eh_o, sw_eh_ready_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (eh_valid_o !== 1'b1 || eh_o !== 1'b0) begin errors++; $display("FAIL sw_stable%0d got=%b%b exp=10", i, eh_valid_o, eh_o); end
        end
        eh_ready_i = 1; tick(); eh_ready_i = 0; #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sw_return got=%b exp=0", busy_o); end
        checks++; if (err_cause_o !== 2'd3 || err_addr_o !== 64'h2000 || num_err_o !== 4'd2) begin errors++; $display("FAIL sw_log got=%0d %h %0d exp=3 2000 2", err_cause_o, err_addr_o, num_err_o); end
        err_ready_i = 1; tick(); err_ready_i = 0;
    endtask

    task automatic test_stall();
        auto_i = 0;
        err_rsp(2'd1, 2'd0, 64'h3000);
        tick();
        rsp_error_i = 0; rsp_last_i = 1; #1;
        checks++; if (rsp_ready_o !== 1'b1) begin errors++; $display("FAIL stall_clean_ready got=%b exp=1", rsp_ready_o); end
        tick();
        err_rsp(2'd1, 2'd3, 64'h3100); #1;
        checks++; if (num_done_o !== 4'd1) begin errors++; $display("FAIL stall_done got=%0d exp=1", num_done_o); end
        checks++; if (rsp_ready_o !== 1'b0) begin errors++; $display("FAIL stall_decide_ready got=%b exp=0", rsp_ready_o); end
        tick();
        checks++; if (rsp_ready_o !== 1'b0 || num_err_o !== 4'd3) begin errors++; $display("FAIL stall_hold got=%b %0d exp=0 3", rsp_ready_o, num_err_o); end
        sw_eh_i = 1; sw_eh_valid_i = 1;
        tick(); sw_eh_valid_i = 0; #1;
        checks++; if (rsp_ready_o !== 1'b0 || eh_o !== 1'b1) begin errors++; $display("FAIL stall_issue got=%b%b exp=01", rsp_ready_o, eh_o); end
        eh_ready_i = 1; tick(); #1;
        checks++; if (rsp_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", rsp_ready_o); end
        tick(); no_rsp(); eh_ready_i = 0; #1;
        checks++; if (num_err_o !== 4'd4 || sw_eh_ready_o !== 1'b1) begin errors++; $display("FAIL stall_accept got=%0d %b exp=4 1", num_err_o, sw_eh_ready_o); end
        sw_eh_valid_i = 1; tick(); sw_eh_valid_i = 0;
        eh_ready_i = 1; tick(); eh_ready_i = 0;
        err_ready_i = 1; tick(); tick(); err_ready_i = 0; #1;
        checks++; if (err_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b%b exp=00", err_valid_o, busy_o); end
    endtask

    task automatic test_overflow();
        clear_i = 1; tick(); clear_i = 0; #1;
        checks++; if (num_err_o !== '0 || num_done_o !== '0) begin errors++; $display("FAIL clear got=%0d,%0d exp=0,0", num_err_o, num_done_o); end
        auto_i = 1; abort_on_err_i = 0; eh_ready_i = 1;
        for (int i = 0; i < 5; i++) begin
            err_rsp(2'd2, 2'd2, 64'h100 + 64'(i));
            tick(); no_rsp(); tick();
        end
        #1;
        checks++; if (num_err_o !== 4'd5 || err_overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flags got=%0d %b exp=5 1", num_err_o, err_overflow_o); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (err_valid_o !== 1'b1 || err_addr_o !== 64'h100 + 64'(i)) begin errors++; $display("FAIL ovf_entry%0d got=%b %h exp=1 %h", i, err_valid_o, err_addr_o, 64'h100 + 64'(i)); end
            err_ready_i = 1; tick(); err_ready_i = 0; #1;
        end
        checks++; if (err_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", err_valid_o); end
    endtask

    task automatic test_full_pop();
        clear_i = 1; tick(); clear_i = 0;
        for (int i = 0; i < 4; i++) begin
            err_rsp(2'd0, 2'd1, 64'h200 + 64'(i));
            tick(); no_rsp(); tick();
        end
        err_rsp(2'd0, 2'd1, 64'h300); err_ready_i = 1;
        tick(); no_rsp(); err_ready_i = 0; tick(); #1;
        checks++; if (err_overflow_o !== 1'b0 || num_err_o !== 4'd5) begin errors++; $display("FAIL fullpop_flags got=%b %0d exp=0 5", err_overflow_o, num_err_o); end
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] exp_addr;
            exp_addr = (i == 3) ? 64'h300 : 64'h201 + 64'(i);
            checks++; if (err_valid_o !== 1'b1 || err_addr_o !== exp_addr) begin errors++; $display("FAIL fullpop_entry%0d got=%b %h exp=1 %h", i, err_valid_o, err_addr_o, exp_addr); end
            err_ready_i = 1; tick(); err_ready_i = 0; #1;
        end
        checks++; if (err_valid_o !== 1'b0) begin errors++; $display("FAIL fullpop_empty got=%b exp=0", err_valid_o); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 12; i++) begin
            err_rsp(2'd1, 2'd1, 64'h400);
            tick(); no_rsp(); tick();
        end
        #1;
        checks++; if (num_err_o !== 4'hF || err_overflow_o !== 1'b1) begin errors++; $display("FAIL saturate got=%0d %b exp=15 1", num_err_o, err_overflow_o); end
        eh_ready_i = 0;
    endtask

    task automatic test_counters();
        clear_i = 1; tick(); clear_i = 0;
        rsp_valid_i = 1; rsp_error_i = 0; rsp_last_i = 1;
        repeat (15) tick();
        checks++; if (num_done_o !== 4'hF) begin errors++; $display("FAIL done_full got=%0d exp=15", num_done_o); end
        tick();
        checks++; if (num_done_o !== 4'h0) begin errors++; $display("FAIL done_wrap got=%0d exp=0", num_done_o); end
        rsp_last_i = 0; tick();
        checks++; if (num_done_o !== 4'h0) begin errors++; $display("FAIL done_notlast got=%0d exp=0", num_done_o); end
        rsp_last_i = 1; tick();
        checks++; if (num_done_o !== 4'h1) begin errors++; $display("FAIL done_inc got=%0d exp=1", num_done_o); end
        clear_i = 1; tick(); clear_i = 0; no_rsp(); #1;
        checks++; if (num_done_o !== 4'h0 || err_overflow_o !== 1'b0) begin errors++; $display("FAIL clear_prio got=%0d %b exp=0 0", num_done_o, err_overflow_o); end
    endtask

    task automatic test_reset_in_issue();
        auto_i = 1; abort_on_err_i = 1; eh_ready_i = 0;
        err_rsp(2'd3, 2'd3, 64'h500);
        tick(); no_rsp(); #1;
        checks++; if (eh_valid_o !== 1'b1 || err_valid_o !== 1'b1) begin errors++; $display("FAIL rst_pre got=%b%b exp=11", eh_valid_o, err_valid_o); end
        rst_ni = 0; #1;
        checks++; if (eh_valid_o !== 1'b0 || eh_o !== 1'b0 || busy_o !== 1'b0 || rsp_ready_o !== 1'b1)
            begin errors++; $display("FAIL rst_fsm got=%b%b%b%b exp=0001", eh_valid_o, eh_o, busy_o, rsp_ready_o); end
        checks++; if (err_valid_o !== 1'b0 || num_err_o !== '0 || num_done_o !== '0 || err_overflow_o !== 1'b0)
            begin errors++; $display("FAIL rst_state got=%b %0d %0d %b exp=0 0 0 0", err_valid_o, num_err_o, num_done_o, err_overflow_o); end
        tick(); rst_ni = 1; tick();
        checks++; if (eh_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_after got=%b%b exp=00", eh_valid_o, busy_o); end
    endtask

    initial begin
        test_reset();
        test_auto_abort();
        test_sw_continue();
        test_stall();
        test_overflow();
        test_full_pop();
        test_saturate();
        test_counters();
        test_reset_in_issue();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
